// File: rtl/delay_echo_seq.sv
// Frame sequencer for the delay-echo datapath: validates the delay header, resets and
// configures the delay line, streams the payload through it and re-frames the echoes.
module delay_echo_seq #(
    parameter int DATA_W    = 32,
    parameter int DELAY_MIN = 2,
    parameter int DELAY_MAX = 100,
    parameter int CNT_W     = 16,
    parameter int FLUSH_TO  = 116
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              o_dl_rst,
    output logic              o_dl_valid,
    output logic [DATA_W-1:0] o_dl_data,
    input  logic              i_dl_valid,
    input  logic [DATA_W-1:0] i_dl_data,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              o_busy,
    output logic              o_err,
    output logic [1:0]        o_err_code
);

    localparam int FTO_W = $clog2(FLUSH_TO + 1);
    localparam logic [DATA_W-1:0] D_MIN    = DATA_W'(DELAY_MIN);
    localparam logic [DATA_W-1:0] D_MAX    = DATA_W'(DELAY_MAX);
    localparam logic [DATA_W-1:0] DATA_Z   = {DATA_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [FTO_W-1:0]  FTO_ZERO = {FTO_W{1'b0}};
    localparam logic [FTO_W-1:0]  FTO_ONE  = FTO_W'(1);
    localparam logic [FTO_W-1:0]  FTO_LAST = FTO_W'(FLUSH_TO - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_CONFIG = 3'd2,
        ST_STREAM = 3'd3,
        ST_FLUSH  = 3'd4,
        ST_DROP   = 3'd5
    } state_t;

    state_t            state_r, state_s;
    logic [DATA_W-1:0] delay_r, delay_s;
    logic [CNT_W-1:0]  tx_cnt_r, tx_cnt_s;
    logic [CNT_W-1:0]  rx_cnt_r, rx_cnt_s;
    logic [FTO_W-1:0]  flush_cnt_r, flush_cnt_s;
    logic              ovf_r, ovf_s;
    logic              err_s;
    logic [1:0]        err_code_r, err_code_s;

    logic              s_ready_r, s_ready_s;
    logic              dl_rst_r, dl_rst_s;
    logic              dl_valid_r, dl_valid_s;
    logic [DATA_W-1:0] dl_data_r, dl_data_s;
    logic              m_valid_r, m_valid_s;
    logic [DATA_W-1:0] m_data_r, m_data_s;
    logic              m_last_r, m_last_s;
    logic              busy_r, busy_s;
    logic              err_r;

    logic accept_s;
    logic hdr_ok_s;
    logic echo_s;

    assign accept_s = s_valid & s_ready_r;
    assign hdr_ok_s = (s_data >= D_MIN) && (s_data <= D_MAX);
    assign echo_s   = ((state_r == ST_STREAM) || (state_r == ST_FLUSH)) && i_dl_valid
                      && (rx_cnt_r < tx_cnt_r);

    // Next-state, counter and error-code logic
    always_comb begin
        state_s     = state_r;
        delay_s     = delay_r;
        tx_cnt_s    = tx_cnt_r;
        flush_cnt_s = FTO_ZERO;
        ovf_s       = ovf_r;
        err_s       = 1'b0;
        err_code_s  = err_code_r;
        if (echo_s) begin
            rx_cnt_s = rx_cnt_r + CNT_ONE;
        end else begin
            rx_cnt_s = rx_cnt_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (!hdr_ok_s) begin
                        err_s      = 1'b1;
                        err_code_s = 2'd1;
                        state_s    = s_last ? ST_IDLE : ST_DROP;
                    end else if (!s_last) begin
                        delay_s = s_data;
                        state_s = ST_CLEAR;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                tx_cnt_s = CNT_ZERO;
                rx_cnt_s = CNT_ZERO;
                ovf_s    = 1'b0;
                state_s  = ST_CONFIG;
            end
            ST_CONFIG: begin
                state_s = ST_STREAM;
            end
            ST_STREAM: begin
                if (accept_s) begin
                    tx_cnt_s = tx_cnt_r + CNT_ONE;
                    if (s_last) begin
                        state_s = ST_FLUSH;
                    end else if (tx_cnt_s == CNT_MAX) begin
                        // Frame longer than the counter: drain what we have, drop the rest later
                        err_s      = 1'b1;
                        err_code_s = 2'd2;
                        ovf_s      = 1'b1;
                        state_s    = ST_FLUSH;
                    end else begin
                        state_s = ST_STREAM;
                    end
                end else begin
                    state_s = ST_STREAM;
                end
            end
            ST_FLUSH: begin
                if (rx_cnt_r == tx_cnt_r) begin
                    state_s = ovf_r ? ST_DROP : ST_IDLE;
                end else if (flush_cnt_r == FTO_LAST) begin
                    err_s      = 1'b1;
                    err_code_s = 2'd3;
                    state_s    = ST_IDLE;
                end else begin
                    flush_cnt_s = flush_cnt_r + FTO_ONE;
                    state_s     = ST_FLUSH;
                end
            end
            ST_DROP: begin
                if (accept_s && s_last) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DROP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs, derived from the upcoming state
    always_comb begin
        case (state_s)
            ST_IDLE:   s_ready_s = 1'b1;
            ST_DROP:   s_ready_s = 1'b1;
            ST_STREAM: s_ready_s = (tx_cnt_s != CNT_MAX);
            default:   s_ready_s = 1'b0;
        endcase
        dl_rst_s = (state_s == ST_CLEAR);
        busy_s   = (state_s != ST_IDLE);
        if (state_s == ST_CONFIG) begin
            dl_valid_s = 1'b1;
            dl_data_s  = delay_r;
        end else if ((state_r == ST_STREAM) && accept_s) begin
            dl_valid_s = 1'b1;
            dl_data_s  = s_data;
        end else begin
            dl_valid_s = 1'b0;
            dl_data_s  = DATA_Z;
        end
        if (echo_s) begin
            m_valid_s = 1'b1;
            m_data_s  = i_dl_data;
            m_last_s  = (state_r == ST_FLUSH) && ((rx_cnt_r + CNT_ONE) == tx_cnt_r);
        end else begin
            m_valid_s = 1'b0;
            m_data_s  = DATA_Z;
            m_last_s  = 1'b0;
        end
    end

    // State, counters and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= ST_IDLE;
            delay_r     <= DATA_Z;
            tx_cnt_r    <= CNT_ZERO;
            rx_cnt_r    <= CNT_ZERO;
            flush_cnt_r <= FTO_ZERO;
            ovf_r       <= 1'b0;
            err_code_r  <= 2'd0;
            err_r       <= 1'b0;
            s_ready_r   <= 1'b0;
            dl_rst_r    <= 1'b1;
            dl_valid_r  <= 1'b0;
            dl_data_r   <= DATA_Z;
            m_valid_r   <= 1'b0;
            m_data_r    <= DATA_Z;
            m_last_r    <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            delay_r     <= delay_s;
            tx_cnt_r    <= tx_cnt_s;
            rx_cnt_r    <= rx_cnt_s;
            flush_cnt_r <= flush_cnt_s;
            ovf_r       <= ovf_s;
            err_code_r  <= err_code_s;
            err_r       <= err_s;
            s_ready_r   <= s_ready_s;
            dl_rst_r    <= dl_rst_s;
            dl_valid_r  <= dl_valid_s;
            dl_data_r   <= dl_data_s;
            m_valid_r   <= m_valid_s;
            m_data_r    <= m_data_s;
            m_last_r    <= m_last_s;
            busy_r      <= busy_s;
        end
    end

    assign s_ready    = s_ready_r;
    assign o_dl_rst   = dl_rst_r;
    assign o_dl_valid = dl_valid_r;
    assign o_dl_data  = dl_data_r;
    assign m_valid    = m_valid_r;
    assign m_data     = m_data_r;
    assign m_last     = m_last_r;
    assign o_busy     = busy_r;
    assign o_err      = err_r;
    assign o_err_code = err_code_r;

endmodule

// File: tb/tb_delay_echo_seq.sv
// Directed bench for delay_echo_seq: cycle table for a normal frame, then hand-written
// sequences for bad headers, flush timeout, counter overflow and mid-frame reset.
module tb_delay_echo_seq;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = 32'd0;
    logic        s_last = 1'b0;
    logic        o_dl_rst;
    logic        o_dl_valid;
    logic [31:0] o_dl_data;
    logic        i_dl_valid = 1'b0;
    logic [31:0] i_dl_data = 32'd0;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_last;
    logic        o_busy;
    logic        o_err;
    logic [1:0]  o_err_code;

    delay_echo_seq #(.DATA_W(32), .DELAY_MIN(2), .DELAY_MAX(100), .CNT_W(3), .FLUSH_TO(116)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .o_dl_rst(o_dl_rst), .o_dl_valid(o_dl_valid), .o_dl_data(o_dl_data),
        .i_dl_valid(i_dl_valid), .i_dl_data(i_dl_data),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
        .o_busy(o_busy), .o_err(o_err), .o_err_code(o_err_code)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Delay line model: first beat after its reset is the delay, later beats return after it
    logic [31:0] dq_data[$];
    int          dq_due[$];
    logic        cfg_pend  = 1'b1;
    int          mdelay    = 2;
    logic        model_off = 1'b0;

    always @(negedge i_clk) begin
        i_dl_valid = 1'b0;
        i_dl_data  = 32'd0;
        if (o_dl_rst) begin
            dq_data.delete();
            dq_due.delete();
            cfg_pend = 1'b1;
        end else begin
            if (dq_due.size() > 0 && dq_due[0] == cyc) begin
                if (!model_off) begin
                    i_dl_valid = 1'b1;
                    i_dl_data  = dq_data[0];
                end
                void'(dq_data.pop_front());
                void'(dq_due.pop_front());
            end
            if (o_dl_valid) begin
                if (cfg_pend) begin
                    mdelay   = int'(o_dl_data);
                    cfg_pend = 1'b0;
                end else begin
                    dq_data.push_back(o_dl_data);
                    dq_due.push_back(cyc + mdelay);
                end
            end
        end
    end

    // Output monitor
    logic [31:0] got_d[$];
    logic        got_l[$];
    logic [1:0]  err_c[$];
    int          err_t[$];
    int          dl_rst_cnt = 0;
    int          dl_vld_cnt = 0;

    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (m_valid) begin
                got_d.push_back(m_data);
                got_l.push_back(m_last);
            end
            if (o_err) begin
                err_c.push_back(o_err_code);
                err_t.push_back(cyc);
            end
            if (o_dl_rst) dl_rst_cnt++;
            if (o_dl_valid) dl_vld_cnt++;
        end
    end

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int n;
        @(negedge i_clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        n = 0;
        while (!s_ready && n < 300) begin
            @(negedge i_clk);
            n++;
        end
        acc_cyc = cyc;
        check1($sformatf("accept_0x%0h", d), s_ready, 1'b1);
        @(posedge i_clk);
    endtask

    task automatic idle();
        @(negedge i_clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 32'd0;
    endtask

    task automatic start_test();
        got_d.delete();
        got_l.delete();
        err_c.delete();
        err_t.delete();
        dl_rst_cnt = 0;
        dl_vld_cnt = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_dl_rst"}, o_dl_rst, 1'b1);
        check1({tag, "_s_ready"}, s_ready, 1'b0);
        check1({tag, "_dl_valid"}, o_dl_valid, 1'b0);
        check1({tag, "_m_valid"}, m_valid, 1'b0);
        check1({tag, "_m_last"}, m_last, 1'b0);
        check1({tag, "_err"}, o_err, 1'b0);
        check1({tag, "_busy"}, o_busy, 1'b0);
        check32({tag, "_dl_data"}, o_dl_data, 32'd0);
        check32({tag, "_m_data"}, m_data, 32'd0);
        check32({tag, "_err_code"}, 32'(o_err_code), 32'd0);
    endtask

    typedef struct {
        logic        vld;
        logic [31:0] data;
        logic        last;
        logic        rdy;
        logic        dl_rst;
        logic        dl_vld;
        logic [31:0] dl_data;
        logic        m_vld;
        logic [31:0] m_data;
        logic        m_last;
        logic        busy;
    } vec_t;

    function automatic vec_t mk(input logic vld, input logic [31:0] data, input logic last,
                                input logic rdy, input logic dl_rst, input logic dl_vld,
                                input logic [31:0] dl_data, input logic m_vld,
                                input logic [31:0] m_data_e, input logic m_last_e,
                                input logic busy);
        vec_t v;
        v.vld = vld; v.data = data; v.last = last;
        v.rdy = rdy; v.dl_rst = dl_rst; v.dl_vld = dl_vld; v.dl_data = dl_data;
        v.m_vld = m_vld; v.m_data = m_data_e; v.m_last = m_last_e; v.busy = busy;
        return v;
    endfunction

    vec_t tbl[14];

    initial begin
        // Header 5 then 0x11, 0x22, 0x33; row k = outputs seen and inputs driven in cycle k
        tbl[0]  = mk(1'b1, 32'd5,     1'b0, 1'b1, 1'b0, 1'b0, 32'd0,     1'b0, 32'd0,     1'b0, 1'b0);
        tbl[1]  = mk(1'b1, 32'h11,    1'b0, 1'b0, 1'b1, 1'b0, 32'd0,     1'b0, 32'd0,     1'b0, 1'b1);
        tbl[2]  = mk(1'b1, 32'h11,    1'b0, 1'b0, 1'b0, 1'b1, 32'd5,     1'b0, 32'd0,     1'b0, 1'b1);
        tbl[3]  = mk(1'b1, 32'h11,    1'b0, 1'b1, 1'b0, 1'b0, 32'd0,     1'b0, 32'd0,     1'b0, 1'b1);
        tbl[4]  = mk(1'b1, 32'h22,    1'b0, 1'b1, 1'b0, 1'b1, 32'h11,    1'b0, 32'd0,     1'b0, 1'b1);
        tbl[5]  = mk(1'b1, 32'h33,    1'b1, 1'b1, 1'b0, 1'b1, 32'h22,    1'b0, 32'd0,     1'b0, 1'b1);
        tbl[6]  = mk(1'b0, 32'd0,     1'b0, 1'b0, 1'b0, 1'b1, 32'h33,    1'b0, 32'd0,     1'b0, 1'b1);
        tbl[7]  = mk(1'b0, 32'd0,     1'b0, 1'b0, 1'b0, 1'b0, 32'd0,     1'b0, 32'd0,     1'b0, 1'b1);
        tbl[8]  = mk(1'b0, 32'd0,     1'b0, 1'b0, 1'b0, 1'b0, 32'd0,     1'b0, 32'd0,     1'b0, 1'b1);
        tbl[9]  = mk(1'b0, 32'd0,     1'b0, 1'b0, 1'b0, 1'b0, 32'd0,     1'b0, 32'd0,     1'b0, 1'b1);
        tbl[10] = mk(1'b0, 32'd0,     1'b0, 1'b0, 1'b0, 1'b0, 32'd0,     1'b1, 32'h11,    1'b0, 1'b1);
        tbl[11] = mk(1'b0, 32'd0,     1'b0, 1'b0, 1'b0, 1'b0, 32'd0,     1'b1, 32'h22,    1'b0, 1'b1);
        tbl[12] = mk(1'b0, 32'd0,     1'b0, 1'b0, 1'b0, 1'b0, 32'd0,     1'b1, 32'h33,    1'b1, 1'b1);
        tbl[13] = mk(1'b0, 32'd0,     1'b0, 1'b1, 1'b0, 1'b0, 32'd0,     1'b0, 32'd0,     1'b0, 1'b0);

        repeat (3) @(negedge i_clk);
        check_reset_outputs("rst");
        i_rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            @(negedge i_clk);
            check1($sformatf("t1_r%0d_ready", i), s_ready, tbl[i].rdy);
            check1($sformatf("t1_r%0d_dl_rst", i), o_dl_rst, tbl[i].dl_rst);
            check1($sformatf("t1_r%0d_dl_valid", i), o_dl_valid, tbl[i].dl_vld);
            if (tbl[i].dl_vld) check32($sformatf("t1_r%0d_dl_data", i), o_dl_data, tbl[i].dl_data);
            check1($sformatf("t1_r%0d_m_valid", i), m_valid, tbl[i].m_vld);
            if (tbl[i].m_vld) check32($sformatf("t1_r%0d_m_data", i), m_data, tbl[i].m_data);
            check1($sformatf("t1_r%0d_m_last", i), m_last, tbl[i].m_last);
            check1($sformatf("t1_r%0d_busy", i), o_busy, tbl[i].busy);
            check1($sformatf("t1_r%0d_err", i), o_err, 1'b0);
            s_valid = tbl[i].vld;
            s_data  = tbl[i].data;
            s_last  = tbl[i].last;
        end

        // Header below range followed by two payload beats
        start_test();
        send(32'd1, 1'b0);
        begin
            int hdr_cyc;
            hdr_cyc = acc_cyc;
            send(32'hA, 1'b0);
            send(32'hB, 1'b1);
            idle();
            repeat (3) @(negedge i_clk);
            check_int("t2_err_count", err_c.size(), 1);
            check32("t2_err_code", 32'(err_c[0]), 32'd1);
            check_int("t2_err_cycle", err_t[0], hdr_cyc + 1);
            check_int("t2_dl_rst_count", dl_rst_cnt, 0);
            check_int("t2_dl_valid_count", dl_vld_cnt, 0);
            check1("t2_busy_after", o_busy, 1'b0);
        end

        // Header above range with last, then a single-beat frame at DELAY_MAX
        start_test();
        send(32'd101, 1'b1);
        idle();
        repeat (2) @(negedge i_clk);
        check_int("t3_err_count", err_c.size(), 1);
        check32("t3_err_code", 32'(err_c[0]), 32'd1);
        check1("t3_busy", o_busy, 1'b0);
        check1("t3_ready", s_ready, 1'b1);
        send(32'd100, 1'b0);
        send(32'h5A, 1'b1);
        idle();
        repeat (130) @(negedge i_clk);
        check_int("t3_echo_count", got_d.size(), 1);
        check32("t3_echo_data", got_d[0], 32'h5A);
        check1("t3_echo_last", got_l[0], 1'b1);
        check_int("t3_err_count_after", err_c.size(), 1);
        check1("t3_busy_after", o_busy, 1'b0);

        // Delay line never answers: flush timeout
        start_test();
        model_off = 1'b1;
        send(32'd4, 1'b0);
        send(32'h1, 1'b0);
        send(32'h2, 1'b0);
        send(32'h3, 1'b1);
        begin
            int last_cyc;
            last_cyc = acc_cyc;
            idle();
            repeat (130) @(negedge i_clk);
            check_int("t4_err_count", err_c.size(), 1);
            check32("t4_err_code", 32'(err_c[0]), 32'd3);
            check_int("t4_err_cycle", err_t[0], last_cyc + 1 + 116);
        end
        check1("t4_busy", o_busy, 1'b0);
        check1("t4_ready", s_ready, 1'b1);
        check32("t4_code_held", 32'(o_err_code), 32'd3);
        check_int("t4_echo_count", got_d.size(), 0);
        model_off = 1'b0;

        // Counter overflow with CNT_W=3: seven beats fit, beats 8 and 9 are dropped
        start_test();
        send(32'd2, 1'b0);
        for (int b = 1; b <= 7; b++) send(32'(b), 1'b0);
        @(negedge i_clk);
        check1("t5_ready_low", s_ready, 1'b0);
        check1("t5_err_pulse", o_err, 1'b1);
        check32("t5_err_code", 32'(o_err_code), 32'd2);
        send(32'd8, 1'b0);
        send(32'd9, 1'b1);
        idle();
        repeat (10) @(negedge i_clk);
        check_int("t5_echo_count", got_d.size(), 7);
        for (int k = 0; k < 7; k++) begin
            if (k < got_d.size()) begin
                check32($sformatf("t5_echo%0d_data", k), got_d[k], 32'(k + 1));
                check1($sformatf("t5_echo%0d_last", k), got_l[k], (k == 6));
            end
        end
        check_int("t5_dl_valid_count", dl_vld_cnt, 8);
        check_int("t5_err_count", err_c.size(), 1);
        check1("t5_busy_after", o_busy, 1'b0);

        // Reset in the middle of a frame
        start_test();
        send(32'd3, 1'b0);
        send(32'hA1, 1'b0);
        send(32'hA2, 1'b0);
        @(negedge i_clk);
        i_rst   = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge i_clk);
        check_reset_outputs("t6");
        i_rst = 1'b0;
        @(negedge i_clk);
        check1("t6_ready_after", s_ready, 1'b1);
        check1("t6_dl_rst_after", o_dl_rst, 1'b0);
        check1("t6_busy_after", o_busy, 1'b0);
        repeat (10) @(negedge i_clk);
        check_int("t6_echo_count", got_d.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
